uart_bram_burst_ctrl: RTL and testbench
=======================================

// Module: uart_bram_burst_ctrl
// PURPOSE
// Command engine between the UART byte receiver/transmitter and a single-port BRAM.
// Parametrised successor of the single-word UART BRAM interface.
// - Parses framed commands carrying multi-byte addresses and data, with burst lengths of 1..256 words.
// - Every frame carries an XOR checksum.
// - Returns ACK/NAK status and read data over a valid/ready TX byte stream.
// - Aborts stalled frames on an inter-byte timeout.
// PARAMETERS
// ADDR_W       8      BRAM address width (ADDR_W <= 8*ADDR_BYTES)
// ADDR_BYTES   1      address bytes per frame, MSB first; bits above ADDR_W ignored
// DATA_BYTES   1      bytes per BRAM word, MSB first; DATA_W = 8*DATA_BYTES
// RD_LAT       1      BRAM read latency in cycles (1 or 2)
// TIMEOUT_CYC  50000  idle clk cycles allowed between rx bytes inside a frame
// PORTS
// clk         in   1            system clock
// reset       in   1            synchronous, active-high reset
// rx_data     in   8            received byte
// rx_valid    in   1            1-cycle strobe per received byte; no backpressure
// tx_data     out  8            byte to transmit
// tx_valid    out  1            tx_data valid; held until accepted
// tx_ready    in   1            transmitter accepts on tx_valid&&tx_ready at posedge
// bram_en     out  1            BRAM access strobe
// bram_we     out  1            write enable (qualified by bram_en)
// bram_addr   out  ADDR_W       BRAM address
// bram_wdata  out  DATA_W       BRAM write data
// bram_rdata  in   DATA_W       BRAM read data, valid RD_LAT cycles after bram_en&&!bram_we
// busy        out  1            high whenever state != IDLE
// frame_err   out  1            1-cycle pulse: timeout, or rx byte dropped while transmitting
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters and checksum cleared.
//   Reset mid-frame aborts the frame; no further BRAM writes, and tx_valid drops immediately.
// - Frame: SYNC(0xAA) CMD ADDR[ADDR_BYTES] LEN [DATA] CHK. Burst length N = LEN+1.
// - CHK is the XOR of every byte from CMD through the last byte before CHK (SYNC excluded).
// - CMD 0x01 WRITE: DATA is N*DATA_BYTES bytes.
//   - Each word is written (bram_en=bram_we=1 for exactly 1 cycle) once its last byte is received.
//   - Address increments per word and wraps modulo 2^ADDR_W.
//   - On CHK: match -> send 0x06 (ACK); mismatch -> send 0x15 (NAK). Words already written are not rolled back.
// - CMD 0x02 READ: there is no DATA field.
//   - CHK mismatch -> send NAK only, with no BRAM access.
//   - CHK match -> send ACK, then N words, then a data checksum (XOR of all data bytes sent).
//   - Per word: a 1-cycle read strobe, RD_LAT-cycle wait, capture, then DATA_BYTES bytes MSB first.
//   - The next read issues only after the last byte of the current word is accepted.
//   - Address wraps as for WRITE.
// - Any other CMD: send NAK immediately and return to IDLE.
// - States: IDLE, CMD, ADDR, LEN, WDATA, WCOMMIT, CHK, RD_ISSUE, RD_WAIT, TX_WORD, TX_STAT, TX_CHK.
// - In IDLE, non-0xAA bytes are silently discarded.
// - Timeout: with busy high in a receive state (CMD..CHK) and no rx_valid for TIMEOUT_CYC cycles:
//   pulse frame_err, return to IDLE, send nothing. Timeout is not counted in TX states.
// - rx_valid while in a TX state: the byte is dropped and frame_err pulses.
// - rx_valid and timeout expiry in the same cycle: the byte wins; the counter restarts.
// - tx_data/tx_valid change only after acceptance. A new byte is presented no earlier than the cycle after acceptance.
// - A completed response returns the engine to IDLE in the cycle after the final byte is accepted.
// TESTING (defaults unless noted; frames in hex)
// 1 Write then read: AA 01 0A 00 55 5E -> one write addr 0A=55, tx 06.
//   Then AA 02 0A 00 08 -> tx 06 55 55.
// 2 Burst wrap: AA 01 FE 02 11 22 33 FD -> writes FE=11, FF=22, 00=33 in order, tx 06.
//   Read back LEN=02 from FE -> 06 11 22 33 00.
// 3 Bad checksum: AA 02 0A 00 09 -> tx 15 only, bram_en never asserted.
//   AA 01 0A 00 77 00 -> 0A=77 written, tx 15.
// 4 Unknown CMD / junk: 13 AA 07 -> 13 ignored, tx 15, busy low afterwards.
//   A following valid frame is processed normally.
// 5 Timeout and backpressure: AA 01 0A then silence -> frame_err at TIMEOUT_CYC, no tx.
//   Then a read with tx_ready stalled 100 cycles per byte -> identical bytes, tx_data stable while stalled.
// 6 Wide config (ADDR_W=12, ADDR_BYTES=2, DATA_BYTES=2, RD_LAT=2): write 1234 at 0ABC -> tx 06.
//   Read back -> 06 12 34 26, with bram_rdata captured exactly 2 cycles after the strobe.

Source files
------------

// File: rtl/uart_bram_burst_ctrl.sv
// Framed UART command engine driving a single-port BRAM: burst writes and reads
// with XOR-checked frames, ACK/NAK status, and an inter-byte receive timeout.
module uart_bram_burst_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int ADDR_BYTES  = 1,
  parameter int DATA_BYTES  = 1,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    bram_en,
  output logic                    bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [8*DATA_BYTES-1:0] bram_wdata,
  input  logic [8*DATA_BYTES-1:0] bram_rdata,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int BC_MAX = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BC_W   = $clog2(BC_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_BYTES - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      LAT_LAST  = 2'(RD_LAT);

  localparam logic [7:0] SYNC   = 8'hAA;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_WDATA, S_WCOMMIT, S_CHK,
    S_RD_ISSUE, S_RD_WAIT, S_TX_WORD, S_TX_STAT, S_TX_CHK
  } state_t;

  state_t            state, state_n, rx_st;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_n;
  logic [7:0]        word_cnt, word_cnt_n;
  logic [7:0]        chk, chk_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [1:0]        lat_cnt, lat_cnt_n;
  logic              rd_pend, rd_pend_n;
  logic [7:0]        stat, stat_n;
  logic              frame_err_n;
  logic [ADDR_W-1:0] addr, addr_n, addr_shift;
  logic [DATA_W-1:0] wword, wword_n, wword_shift;
  logic [DATA_W-1:0] rword, rword_n;
  logic              in_rx;

  // Address and write word are assembled MSB first; surplus address bits fall off the top.
  if (ADDR_W > 8) begin : g_addr_wide
    assign addr_shift = {addr[ADDR_W-9:0], rx_data};
  end else begin : g_addr_narrow
    assign addr_shift = rx_data[ADDR_W-1:0];
  end

  if (DATA_BYTES > 1) begin : g_word_wide
    assign wword_shift = {wword[DATA_W-9:0], rx_data};
  end else begin : g_word_narrow
    assign wword_shift = rx_data;
  end

  assign in_rx = state inside {S_CMD, S_ADDR, S_LEN, S_WDATA, S_WCOMMIT, S_CHK};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      chk       <= '0;
      to_cnt    <= '0;
      lat_cnt   <= '0;
      rd_pend   <= 1'b0;
      stat      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      word_cnt  <= word_cnt_n;
      chk       <= chk_n;
      to_cnt    <= to_cnt_n;
      lat_cnt   <= lat_cnt_n;
      rd_pend   <= rd_pend_n;
      stat      <= stat_n;
      frame_err <= frame_err_n;
    end
  end

  always_ff @(posedge clk) begin
    addr  <= addr_n;
    wword <= wword_n;
    rword <= rword_n;
  end

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    word_cnt_n  = word_cnt;
    chk_n       = chk;
    to_cnt_n    = to_cnt;
    lat_cnt_n   = lat_cnt;
    rd_pend_n   = rd_pend;
    stat_n      = stat;
    frame_err_n = 1'b0;
    addr_n      = addr;
    wword_n     = wword;
    rword_n     = rword;

    // A byte landing during the commit cycle belongs to the state that follows it.
    rx_st = state;
    if (state == S_WCOMMIT) rx_st = (word_cnt == 8'd0) ? S_CHK : S_WDATA;

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC) begin
          state_n = S_CMD;
          chk_n   = '0;
        end
      end
      S_WCOMMIT: begin
        addr_n  = addr + ADDR_W'(1);
        if (word_cnt != 8'd0) word_cnt_n = word_cnt - 8'd1;
        state_n = rx_st;
      end
      S_RD_ISSUE: begin
        state_n   = S_RD_WAIT;
        lat_cnt_n = 2'd1;
      end
      S_RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          rword_n    = bram_rdata;
          byte_cnt_n = '0;
          state_n    = S_TX_WORD;
        end else begin
          lat_cnt_n = lat_cnt + 2'd1;
        end
      end
      S_TX_WORD: begin
        if (tx_ready) begin
          chk_n   = chk ^ rword[DATA_W-1 -: 8];
          rword_n = rword << 8;
          if (byte_cnt == DATA_LAST) begin
            byte_cnt_n = '0;
            if (word_cnt == 8'd0) begin
              state_n = S_TX_CHK;
            end else begin
              word_cnt_n = word_cnt - 8'd1;
              addr_n     = addr + ADDR_W'(1);
              state_n    = S_RD_ISSUE;
            end
          end else begin
            byte_cnt_n = byte_cnt + BC_W'(1);
          end
        end
      end
      S_TX_STAT: if (tx_ready) state_n = rd_pend ? S_RD_ISSUE : S_IDLE;
      S_TX_CHK:  if (tx_ready) state_n = S_IDLE;
      default: ;
    endcase

    if (in_rx && rx_valid) begin
      case (rx_st)
        S_CMD: begin
          chk_n = chk ^ rx_data;
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            rd_pend_n  = (rx_data == CMD_RD);
            byte_cnt_n = '0;
            state_n    = S_ADDR;
          end else begin
            rd_pend_n = 1'b0;
            stat_n    = NAK;
            state_n   = S_TX_STAT;
          end
        end
        S_ADDR: begin
          chk_n  = chk ^ rx_data;
          addr_n = addr_shift;
          if (byte_cnt == ADDR_LAST) begin
            byte_cnt_n = '0;
            state_n    = S_LEN;
          end else begin
            byte_cnt_n = byte_cnt + BC_W'(1);
          end
        end
        S_LEN: begin
          chk_n      = chk ^ rx_data;
          word_cnt_n = rx_data;
          state_n    = rd_pend ? S_CHK : S_WDATA;
        end
        S_WDATA: begin
          chk_n   = chk ^ rx_data;
          wword_n = wword_shift;
          if (byte_cnt == DATA_LAST) begin
            byte_cnt_n = '0;
            state_n    = S_WCOMMIT;
          end else begin
            byte_cnt_n = byte_cnt + BC_W'(1);
          end
        end
        S_CHK: begin
          stat_n    = (rx_data == chk) ? ACK : NAK;
          rd_pend_n = rd_pend && (rx_data == chk);
          chk_n     = '0;
          state_n   = S_TX_STAT;
        end
        default: ;
      endcase
    end

    // Inter-byte timeout only runs while a frame is being received; a byte always wins.
    if (!in_rx || rx_valid) begin
      to_cnt_n = '0;
    end else if (to_cnt == TO_LAST) begin
      to_cnt_n    = '0;
      state_n     = S_IDLE;
      frame_err_n = 1'b1;
    end else begin
      to_cnt_n = to_cnt + TO_W'(1);
    end

    if (!in_rx && state != S_IDLE && rx_valid) frame_err_n = 1'b1;
  end

  always_comb begin
    tx_valid = state inside {S_TX_WORD, S_TX_STAT, S_TX_CHK};
    case (state)
      S_TX_WORD: tx_data = rword[DATA_W-1 -: 8];
      S_TX_STAT: tx_data = stat;
      S_TX_CHK:  tx_data = chk;
      default:   tx_data = 8'h00;
    endcase
    bram_en    = (state == S_WCOMMIT) || (state == S_RD_ISSUE);
    bram_we    = (state == S_WCOMMIT);
    bram_addr  = bram_en ? addr : '0;
    bram_wdata = bram_we ? wword : '0;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_uart_bram_burst_ctrl.sv
// Directed bench for uart_bram_burst_ctrl: a default-width instance and a wide
// instance, each with its own BRAM model whose read data is only valid RD_LAT cycles after a strobe.
module tb_uart_bram_burst_ctrl;

  localparam int TO = 1000;

  logic clk = 1'b0;
  logic reset, sel, rx_valid, tx_ready;
  logic [7:0] rx_data;

  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, en0, en1, we0, we1, busy0, busy1, ferr0, ferr1;
  logic [7:0]  addr0, wdata0, rdata0;
  logic [11:0] addr1;
  logic [15:0] wdata1, rdata1;

  uart_bram_burst_ctrl #(.TIMEOUT_CYC(TO)) u0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & ~sel),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready & ~sel),
    .bram_en(en0), .bram_we(we0), .bram_addr(addr0), .bram_wdata(wdata0),
    .bram_rdata(rdata0), .busy(busy0), .frame_err(ferr0));

  uart_bram_burst_ctrl #(.ADDR_W(12), .ADDR_BYTES(2), .DATA_BYTES(2), .RD_LAT(2),
                         .TIMEOUT_CYC(TO)) u1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & sel),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready & sel),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_wdata(wdata1),
    .bram_rdata(rdata1), .busy(busy1), .frame_err(ferr1));

  always #5 clk = ~clk;

  // BRAM models: read data is garbage outside its single valid cycle.
  logic [7:0]  mem0 [256];
  logic [15:0] mem1 [4096];
  logic [7:0]  rp0;
  logic [15:0] rp1a, rp1b;
  logic        rv0 = 1'b0, rv1a = 1'b0, rv1b = 1'b0;

  always @(posedge clk) begin
    if (en0 && we0) mem0[addr0] <= wdata0;
    rv0  <= en0 && !we0;
    rp0  <= mem0[addr0];
    if (en1 && we1) mem1[addr1] <= wdata1;
    rv1a <= en1 && !we1;
    rp1a <= mem1[addr1];
    rv1b <= rv1a;
    rp1b <= rp1a;
  end
  assign rdata0 = rv0 ? rp0 : 8'hEE;
  assign rdata1 = rv1b ? rp1b : 16'hBEEF;

  logic [7:0]  t_data;
  logic        t_valid, t_ready, t_en, t_we, t_busy, t_ferr;
  logic [15:0] t_addr, t_wdata;
  assign t_data  = sel ? tx_data1 : tx_data0;
  assign t_valid = sel ? tx_valid1 : tx_valid0;
  assign t_ready = tx_ready;
  assign t_en    = sel ? en1 : en0;
  assign t_we    = sel ? we1 : we0;
  assign t_busy  = sel ? busy1 : busy0;
  assign t_ferr  = sel ? ferr1 : ferr0;
  assign t_addr  = sel ? {4'h0, addr1} : {8'h00, addr0};
  assign t_wdata = sel ? wdata1 : {8'h00, wdata0};

  logic [7:0]  txq [$];
  logic [31:0] wlog [$];
  int en_cnt = 0, fe_cnt = 0, stall_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    if (t_valid && t_ready) txq.push_back(t_data);
    if (t_en) begin
      en_cnt <= en_cnt + 1;
      if (t_we) wlog.push_back({t_addr, t_wdata});
    end
    if (t_ferr) fe_cnt <= fe_cnt + 1;
  end

  always @(negedge clk) begin
    if (prev_stall && (t_valid !== 1'b1 || t_data !== prev_data)) stall_err <= stall_err + 1;
    prev_stall <= t_valid && !t_ready;
    prev_data  <= t_data;
  end

  int n_tests = 0, n_fail = 0;

  function automatic logic [63:0] pack_tx(input int from);
    logic [63:0] r = '0;
    for (int i = from; i < txq.size(); i++) r = {r[55:0], txq[i]};
    return r;
  endfunction

  function automatic logic [95:0] pack_wl(input int from);
    logic [95:0] r = '0;
    for (int i = from; i < wlog.size(); i++) r = {r[63:0], wlog[i]};
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [95:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(f[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (t_busy && k < 400) begin @(negedge clk); k++; end
    n_tests++;
    if (t_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s: busy=%b after %0d cycles, want 0", name, t_busy, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({tx_valid0, tx_data0, en0, we0, addr0, wdata0, busy0, ferr0} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: got %b %h %b %b %h %h %b %b, want all 0",
                         tx_valid0, tx_data0, en0, we0, addr0, wdata0, busy0, ferr0);
    end
    n_tests++;
    if ({tx_valid1, tx_data1, en1, we1, addr1, wdata1, busy1, ferr1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %b %h %b %b %h %h %b %b, want all 0",
                         tx_valid1, tx_data1, en1, we1, addr1, wdata1, busy1, ferr1);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int tb, wb, eb;
    tb = txq.size(); wb = wlog.size();
    send_frame(96'hAA010A00555E, 6);
    wait_idle("wr1_idle");
    n_tests++;
    if (wlog.size() - wb != 1 || wlog[wb] !== 32'h000A0055) begin
      n_fail++; $display("FAIL wr1_write: got %0d writes %h, want 1 write 000a0055", wlog.size() - wb, pack_wl(wb));
    end
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h06) begin
      n_fail++; $display("FAIL wr1_tx: got %0d bytes %h, want 06", txq.size() - tb, pack_tx(tb));
    end
    tb = txq.size(); eb = en_cnt;
    send_frame(96'hAA020A0008, 5);
    wait_idle("rd1_idle");
    n_tests++;
    if (txq.size() - tb != 3 || pack_tx(tb) !== 64'h065555) begin
      n_fail++; $display("FAIL rd1_tx: got %0d bytes %h, want 065555", txq.size() - tb, pack_tx(tb));
    end
    n_tests++;
    if (en_cnt - eb != 1) begin
      n_fail++; $display("FAIL rd1_strobes: got %0d, want 1", en_cnt - eb);
    end
  endtask

  task automatic test_burst_wrap();
    int tb, wb;
    tb = txq.size(); wb = wlog.size();
    send_frame(96'hAA01FE02112233FD, 8);
    wait_idle("burst_wr_idle");
    n_tests++;
    if (wlog.size() - wb != 3 || pack_wl(wb) !== 96'h00FE0011_00FF0022_00000033) begin
      n_fail++; $display("FAIL burst_writes: got %0d writes %h, want 00fe0011 00ff0022 00000033",
                         wlog.size() - wb, pack_wl(wb));
    end
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h06) begin
      n_fail++; $display("FAIL burst_wr_tx: got %0d bytes %h, want 06", txq.size() - tb, pack_tx(tb));
    end
    tb = txq.size();
    send_frame(96'hAA02FE02FE, 5);
    wait_idle("burst_rd_idle");
    n_tests++;
    if (txq.size() - tb != 5 || pack_tx(tb) !== 64'h0611223300) begin
      n_fail++; $display("FAIL burst_rd_tx: got %0d bytes %h, want 0611223300", txq.size() - tb, pack_tx(tb));
    end
  endtask

  task automatic test_bad_chk();
    int tb, wb, eb;
    tb = txq.size(); eb = en_cnt;
    send_frame(96'hAA020A0009, 5);
    wait_idle("badrd_idle");
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h15) begin
      n_fail++; $display("FAIL badrd_tx: got %0d bytes %h, want 15", txq.size() - tb, pack_tx(tb));
    end
    n_tests++;
    if (en_cnt - eb != 0) begin
      n_fail++; $display("FAIL badrd_strobes: got %0d, want 0", en_cnt - eb);
    end
    tb = txq.size(); wb = wlog.size();
    send_frame(96'hAA010A007700, 6);
    wait_idle("badwr_idle");
    n_tests++;
    if (wlog.size() - wb != 1 || wlog[wb] !== 32'h000A0077) begin
      n_fail++; $display("FAIL badwr_write: got %0d writes %h, want 000a0077", wlog.size() - wb, pack_wl(wb));
    end
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h15) begin
      n_fail++; $display("FAIL badwr_tx: got %0d bytes %h, want 15", txq.size() - tb, pack_tx(tb));
    end
  endtask

  task automatic test_unknown_cmd();
    int tb;
    tb = txq.size();
    send_frame(96'h13AA07, 3);
    wait_idle("unk_idle");
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h15) begin
      n_fail++; $display("FAIL unk_tx: got %0d bytes %h, want 15", txq.size() - tb, pack_tx(tb));
    end
    tb = txq.size();
    send_frame(96'hAA020A0008, 5);
    wait_idle("unk_next_idle");
    n_tests++;
    if (txq.size() - tb != 3 || pack_tx(tb) !== 64'h067777) begin
      n_fail++; $display("FAIL unk_next_tx: got %0d bytes %h, want 067777", txq.size() - tb, pack_tx(tb));
    end
  endtask

  task automatic test_timeout();
    int tb, wb, fb, n;
    tb = txq.size(); wb = wlog.size(); fb = fe_cnt; n = 0;
    send_frame(96'hAA010A, 3);
    while (!t_ferr && n < 2 * TO) begin @(negedge clk); n++; end
    n_tests++;
    if (t_ferr !== 1'b1 || n < TO - 10 || n > TO) begin
      n_fail++; $display("FAIL timeout_pulse: frame_err=%b after %0d cycles, want 1 after ~%0d", t_ferr, n, TO - 3);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (fe_cnt - fb != 1 || t_busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_state: got %0d pulses busy=%b, want 1 pulse busy=0", fe_cnt - fb, t_busy);
    end
    n_tests++;
    if (txq.size() != tb || wlog.size() != wb) begin
      n_fail++; $display("FAIL timeout_silent: got %0d tx %0d writes, want 0 0", txq.size() - tb, wlog.size() - wb);
    end
  endtask

  task automatic test_backpressure();
    int tb, sb, fb, k;
    tb = txq.size(); sb = stall_err; fb = fe_cnt;
    tx_ready = 1'b0;
    send_frame(96'hAA020A0008, 5);
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!t_valid && k < 50) begin @(negedge clk); k++; end
      repeat (100) @(negedge clk);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_idle("bp_idle");
    n_tests++;
    if (txq.size() - tb != 3 || pack_tx(tb) !== 64'h067777) begin
      n_fail++; $display("FAIL bp_tx: got %0d bytes %h, want 067777", txq.size() - tb, pack_tx(tb));
    end
    n_tests++;
    if (stall_err - sb != 0 || fe_cnt - fb != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles %0d frame_err, want 0 0", stall_err - sb, fe_cnt - fb);
    end
  endtask

  task automatic test_wide();
    int tb, wb;
    sel = 1'b1;
    @(negedge clk);
    tb = txq.size(); wb = wlog.size();
    send_frame(96'hAA010ABC00123491, 8);
    wait_idle("wide_wr_idle");
    n_tests++;
    if (wlog.size() - wb != 1 || wlog[wb] !== 32'h0ABC1234) begin
      n_fail++; $display("FAIL wide_write: got %0d writes %h, want 0abc1234", wlog.size() - wb, pack_wl(wb));
    end
    n_tests++;
    if (txq.size() - tb != 1 || pack_tx(tb) !== 64'h06) begin
      n_fail++; $display("FAIL wide_wr_tx: got %0d bytes %h, want 06", txq.size() - tb, pack_tx(tb));
    end
    tb = txq.size();
    send_frame(96'hAA020ABC00B4, 6);
    wait_idle("wide_rd_idle");
    n_tests++;
    if (txq.size() - tb != 4 || pack_tx(tb) !== 64'h06123426) begin
      n_fail++; $display("FAIL wide_rd_tx: got %0d bytes %h, want 06123426", txq.size() - tb, pack_tx(tb));
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int tb, wb, k;
    tb = txq.size(); wb = wlog.size();
    send_frame(96'hAA010A015A, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (t_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_frame_busy: got %b, want 0", t_busy);
    end
    send_byte(8'h5B);
    repeat (3) @(negedge clk);
    n_tests++;
    if (wlog.size() - wb != 1 || wlog[wb] !== 32'h000A005A || txq.size() != tb) begin
      n_fail++; $display("FAIL rst_frame_abort: got %0d writes %h %0d tx, want 1 write 000a005a 0 tx",
                         wlog.size() - wb, pack_wl(wb), txq.size() - tb);
    end
    tx_ready = 1'b0;
    send_frame(96'hAA020A0008, 5);
    k = 0;
    while (!t_valid && k < 50) begin @(negedge clk); k++; end
    n_tests++;
    if (t_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_tx_pending: tx_valid=%b, want 1", t_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (t_valid !== 1'b0 || t_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_tx_drop: tx_valid=%b tx_data=%h, want 0 00", t_valid, t_data);
    end
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (txq.size() != tb || t_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_tx_after: got %0d tx busy=%b, want 0 0", txq.size() - tb, t_busy);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_bad_chk();
    test_unknown_cmd();
    test_timeout();
    test_backpressure();
    test_wide();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
